// File: rtl/truth_table_checker.sv
// Response checker for 4-input/2-output logic sweeps: compares observed outputs to a parameter
// truth table, tracks code coverage and first failure. Optional macro: HALT_ON_FAIL_EN.
module truth_table_checker #(
    parameter logic [15:0] EXP1   = 16'h0000,
    parameter logic [15:0] EXP2   = 16'h0000,
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vld,
    output logic             rdy,
    input  logic [3:0]       vec,
    input  logic             out1,
    input  logic             out2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [3:0]       first_err_vec,
    output logic [1:0]       first_err_obs,
    output logic [15:0]      cov_map
);

    typedef enum logic [2:0] {StIdle, StArmed, StSettle, StCheck, StDone} state_e;

    localparam logic [3:0] SettleLoad = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       vec_q, vec_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             first_err_vld_q, first_err_vld_d;
    logic [3:0]       first_err_vec_q, first_err_vec_d;
    logic [1:0]       first_err_obs_q, first_err_obs_d;
    logic [15:0]      cov_map_q, cov_map_d;
    logic             mismatch;
    logic [15:0]      cov_upd;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        vec_d           = vec_q;
        err_cnt_d       = err_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_vec_d = first_err_vec_q;
        first_err_obs_d = first_err_obs_q;
        cov_map_d       = cov_map_q;
        mismatch        = (out1 != EXP1[vec_q]) || (out2 != EXP2[vec_q]);
        cov_upd         = cov_map_q | (16'h0001 << vec_q);

        if (start) begin
            state_d         = StArmed;
            cnt_d           = '0;
            vec_d           = '0;
            err_cnt_d       = '0;
            first_err_vld_d = 1'b0;
            first_err_vec_d = '0;
            first_err_obs_d = '0;
            cov_map_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (vld) begin
                        vec_d   = vec;
                        cnt_d   = SettleLoad;
                        state_d = StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q == 4'd0) state_d = StCheck;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                StCheck: begin
                    // Outputs are sampled here, not at acceptance, to allow the DUT to settle.
                    cov_map_d = cov_upd;
                    if (mismatch) begin
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                        if (!first_err_vld_q) begin
                            first_err_vld_d = 1'b1;
                            first_err_vec_d = vec_q;
                            first_err_obs_d = {out1, out2};
                        end
                    end
                    state_d = (&cov_upd) ? StDone : StArmed;
`ifdef HALT_ON_FAIL_EN
                    if (mismatch) state_d = StDone;
`endif
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            vec_q           <= '0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_vec_q <= '0;
            first_err_obs_q <= '0;
            cov_map_q       <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            vec_q           <= vec_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_vec_q <= first_err_vec_d;
            first_err_obs_q <= first_err_obs_d;
            cov_map_q       <= cov_map_d;
        end
    end

    assign rdy           = (state_q == StArmed);
    assign busy          = (state_q == StArmed) || (state_q == StSettle) || (state_q == StCheck);
    assign done          = (state_q == StDone);
    assign pass          = done && (err_cnt_q == '0);
    assign err_cnt       = err_cnt_q;
    assign first_err_vld = first_err_vld_q;
    assign first_err_vec = first_err_vec_q;
    assign first_err_obs = first_err_obs_q;
    assign cov_map       = cov_map_q;

endmodule
